serial_tx_arbiter: RTL

Shares one pulse-width-coded serial line `txd` among `NREQ` requesters. Each requester offers an 8-bit command: a 5-bit address and a 3-bit LED value. The block arbitrates between pending requests, serializes the winner LSB-first using spacing-length bit coding, and acknowledges completion. It is the transmit-side controller that drives the line feeding the address-matching LED receivers.

---
 rtl/serial_link_pkg.sv | 41 ++++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/serial_tx_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/serial_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_link_pkg
//  Purpose  : Shared definitions for the pulse-width-coded serial LED link
//             (transmit arbiter and address-matching receivers).
//  Revision : 1.0 - initial release
// ============================================================================
package serial_link_pkg;

   // Frame field widths: byte = {addr, val}
   localparam int ADDR_W = 5;
   localparam int VAL_W  = 3;
   localparam int BYTE_W = ADDR_W + VAL_W;

   // Default line timing, in clock cycles
   localparam int SHORT_LEN_DEF = 3;   // spacing run for a '1' bit
   localparam int LONG_LEN_DEF  = 12;  // spacing run for a '0' bit
   localparam int GAP_LEN_DEF   = 3;   // marking run after every bit

   // Controller state encoding (shared with the receiver)
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SPACE = 2'd1;
   localparam logic [1:0] ST_MARK  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef logic [1:0] state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [VAL_W-1:0]  val;
   } frame_t;

   // Spacing run length for one data bit
   function automatic logic [3:0] bit_len(input logic b,
                                          input int   short_len,
                                          input int   long_len);
      return b ? 4'(short_len) : 4'(long_len);
   endfunction

endpackage : serial_link_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational winner selection among NREQ requesters. Searches
//             upward from ptr with wrap-around; returns one-hot grant + index.
//             With SERIAL_TX_FIXED_PRIO_EN defined, ptr is ignored and the
//             lowest requesting index always wins.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] w_start;

`ifdef SERIAL_TX_FIXED_PRIO_EN
   logic w_unused_ptr;
   assign w_unused_ptr = ^ptr;
   assign w_start      = '0;
`else
   assign w_start = ptr;
`endif

   // First requester at or after the start index wins, wrapping past NREQ-1
   always_comb begin
      int  j;
      logic found;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(w_start) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = IDX_W'(j);
         end
      end
   end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx_arbiter
//  Purpose  : Shares one pulse-width-coded serial line among NREQ requesters.
//             Latches the winner's {addr,val} byte, sends it LSB first as
//             spacing runs (short = 1, long = 0) each followed by a marking
//             gap, then pulses ack to the winner.
//             Macro SERIAL_TX_FIXED_PRIO_EN: fixed priority, no RR pointer.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_tx_arbiter
   import serial_link_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int SHORT_LEN = SHORT_LEN_DEF,
   parameter int LONG_LEN  = LONG_LEN_DEF,
   parameter int GAP_LEN   = GAP_LEN_DEF
) (
   input  logic                   clock,
   input  logic                   reset_,
   input  logic [NREQ-1:0]        req,
   input  logic [ADDR_W*NREQ-1:0] addr,
   input  logic [VAL_W*NREQ-1:0]  val,
   output logic [NREQ-1:0]        ack,
   output logic                   txd,
   output logic                   busy
);

   localparam int IDX_W = $clog2(NREQ);

   state_t            state_q,  state_d;
   logic [7:0]        shift_q,  shift_d;
   logic [2:0]        bitcnt_q, bitcnt_d;
   logic [3:0]        cnt_q,    cnt_d;
   logic [NREQ-1:0]   grant_q,  grant_d;

   logic [NREQ-1:0]   w_win_grant;
   logic [IDX_W-1:0]  w_win_idx;
   logic [IDX_W-1:0]  w_ptr;
   frame_t            w_win_frame;

`ifdef SERIAL_TX_FIXED_PRIO_EN
   logic w_unused_idx;
   assign w_unused_idx = ^w_win_idx;
   assign w_ptr        = '0;
`else
   logic [IDX_W-1:0]  ptr_q,  ptr_d;
   logic [IDX_W-1:0]  widx_q, widx_d;
   assign w_ptr = ptr_q;
`endif

   rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req   (req),
      .ptr   (w_ptr),
      .grant (w_win_grant),
      .idx   (w_win_idx)
   );

   assign w_win_frame.addr = addr[int'(w_win_idx)*ADDR_W +: ADDR_W];
   assign w_win_frame.val  = val[int'(w_win_idx)*VAL_W +: VAL_W];

   // Frame sequencer: grant, spacing/marking runs per bit, completion
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bitcnt_d = bitcnt_q;
      cnt_d    = cnt_q;
      grant_d  = grant_q;
`ifndef SERIAL_TX_FIXED_PRIO_EN
      ptr_d    = ptr_q;
      widx_d   = widx_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               shift_d  = w_win_frame;
               grant_d  = w_win_grant;
               bitcnt_d = 3'd0;
               cnt_d    = bit_len(w_win_frame.val[0], SHORT_LEN, LONG_LEN);
               state_d  = ST_SPACE;
`ifndef SERIAL_TX_FIXED_PRIO_EN
               widx_d   = w_win_idx;
`endif
            end
         end
         ST_SPACE: begin
            if (cnt_q == 4'd1) begin
               cnt_d   = 4'(GAP_LEN);
               state_d = ST_MARK;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_MARK: begin
            if (cnt_q == 4'd1) begin
               if (bitcnt_q == 3'd7) begin
                  state_d = ST_DONE;
               end else begin
                  shift_d  = {1'b0, shift_q[7:1]};
                  bitcnt_d = bitcnt_q + 3'd1;
                  cnt_d    = bit_len(shift_q[1], SHORT_LEN, LONG_LEN);
                  state_d  = ST_SPACE;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
`ifndef SERIAL_TX_FIXED_PRIO_EN
            ptr_d   = (int'(widx_q) == NREQ - 1) ? '0 : widx_q + 1'b1;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset abandons any partial frame
   always_ff @(posedge clock) begin
      if (!reset_) begin
         state_q  <= ST_IDLE;
         shift_q  <= '0;
         bitcnt_q <= '0;
         cnt_q    <= '0;
         grant_q  <= '0;
`ifndef SERIAL_TX_FIXED_PRIO_EN
         ptr_q    <= '0;
         widx_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         bitcnt_q <= bitcnt_d;
         cnt_q    <= cnt_d;
         grant_q  <= grant_d;
`ifndef SERIAL_TX_FIXED_PRIO_EN
         ptr_q    <= ptr_d;
         widx_q   <= widx_d;
`endif
      end
   end

   // Outputs decoded purely from registered state
   assign txd  = (state_q != ST_SPACE);
   assign busy = (state_q != ST_IDLE);
   assign ack  = (state_q == ST_DONE) ? grant_q : '0;

endmodule : serial_tx_arbiter
`default_nettype wire
